muldiv_div_unit: RTL

- Iterative RV32M divide unit executing DIV, DIVU, REM and REMU.
- Sits beside the single-cycle integer ALU in execute: the ALU covers all 1-cycle ops; this block takes the multi-cycle divide path.
- Operands enter and results leave over valid/ready handshakes, so the pipeline stalls execute while the unit is busy.
- Radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/muldiv_div_unit_pkg.sv | 48 ++++
 rtl/muldiv_div_unit_if.sv | 27 ++
 rtl/muldiv_div_unit_div_step.sv | 33 +++
 rtl/muldiv_div_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_div_unit_pkg.sv
// Shared definitions for the execute-stage divide path. The ALU select
// encodings live here as well so that decode takes both from one package.
package muldiv_div_unit_pkg;

  // Default operand/result width.
  localparam int DIV_XLEN = 32;

  // Divide operation encodings, as carried on the op input.
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // Single-cycle ALU operation select, decoded in the same stage.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_sel_e;

  // DIV and REM treat their operands as two's complement; bit 0 clear.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder; bit 1 set.
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_div_unit_if.sv
// Operand/result handshake bundle between execute and the divide unit.
interface muldiv_div_unit_if
  import muldiv_div_unit_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] div_res;

  // Execute-stage side: issues operands and consumes results.
  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, div_res
  );

  // Divide unit side.
  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, div_res
  );
endinterface

// File: rtl/muldiv_div_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor when it fits.
module muldiv_div_unit_div_step
  import muldiv_div_unit_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  // The shifted remainder can need XLEN+1 bits (remainder < divisor up to
  // 2^XLEN-1), so the compare/subtract is done one bit wider.
  logic [XLEN:0] partial_s;
  logic [XLEN:0] diff_s;

  // Shift, trial subtract and restore when the divisor does not fit.
  always_comb begin
    partial_s = {rem_i, quo_i[XLEN-1]};
    diff_s    = partial_s - {1'b0, divisor_i};
    if (partial_s >= {1'b0, divisor_i}) begin
      rem_o = diff_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = partial_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Operates on magnitudes and applies the sign fixup when the result is
// registered; divide-by-zero and signed overflow bypass the iteration.
module muldiv_div_unit
  import muldiv_div_unit_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = 6
) (
  input logic              clock,
  input logic              reset,
  input logic              flush,
  muldiv_div_unit_if.slave bus
);

  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  // Two's complement negate when requested.
  function automatic logic [XLEN-1:0] cond_negate(input logic neg, input logic [XLEN-1:0] v);
    if (neg) begin
      return ~v + ONE;
    end else begin
      return v;
    end
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  divisor_q, divisor_d;
  logic [XLEN-1:0]  div_res_q, div_res_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             signed_op_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [XLEN-1:0]  abs_a_s;
  logic [XLEN-1:0]  abs_b_s;
  logic             div_zero_s;
  logic             ovf_s;
  logic [XLEN-1:0]  special_res_s;
  logic [XLEN-1:0]  step_rem_s;
  logic [XLEN-1:0]  step_quo_s;
  logic [XLEN-1:0]  final_res_s;

  muldiv_div_unit_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem_s),
    .quo_o     (step_quo_s)
  );

  // Operand decode: sign flags, magnitudes and the results that skip iteration.
  always_comb begin
    signed_op_s = op_is_signed(bus.op);
    a_neg_s     = signed_op_s & bus.A[XLEN-1];
    b_neg_s     = signed_op_s & bus.B[XLEN-1];
    abs_a_s     = cond_negate(a_neg_s, bus.A);
    abs_b_s     = cond_negate(b_neg_s, bus.B);
    div_zero_s  = (bus.B == ZERO);
    ovf_s       = signed_op_s && (bus.A == INT_MIN) && (bus.B == ALL_ONES);
    if (div_zero_s) begin
      special_res_s = op_is_rem(bus.op) ? bus.A : ALL_ONES;
    end else if (ovf_s) begin
      special_res_s = op_is_rem(bus.op) ? ZERO : INT_MIN;
    end else begin
      special_res_s = ZERO;
    end
  end

  // Signed result of the last iteration: quotient negated on sign mismatch,
  // remainder follows the dividend.
  always_comb begin
    if (is_rem_q) begin
      final_res_s = cond_negate(neg_rem_q, step_rem_s);
    end else begin
      final_res_s = cond_negate(neg_quo_q, step_quo_s);
    end
  end

  // Next-state logic: accept, iterate, present result; flush overrides all.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    divisor_d   = divisor_q;
    div_res_d   = div_res_q;
    is_rem_d    = is_rem_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      state_d     = ST_IDLE;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            is_rem_d   = op_is_rem(bus.op);
            neg_quo_d  = a_neg_s ^ b_neg_s;
            neg_rem_d  = a_neg_s;
            rem_d      = ZERO;
            quo_d      = abs_a_s;
            divisor_d  = abs_b_s;
            in_ready_d = 1'b0;
            if (div_zero_s || ovf_s) begin
              div_res_d   = special_res_s;
              out_valid_d = 1'b1;
              cnt_d       = {CNT_W{1'b0}};
              state_d     = ST_DONE;
            end else begin
              cnt_d   = CNT_W'(XLEN);
              state_d = ST_CALC;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            div_res_d   = final_res_s;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      rem_q       <= ZERO;
      quo_q       <= ZERO;
      divisor_q   <= ZERO;
      div_res_q   <= ZERO;
      is_rem_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      divisor_q   <= divisor_d;
      div_res_q   <= div_res_d;
      is_rem_q    <= is_rem_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.div_res   = div_res_q;

endmodule
